// File: rtl/jag_pad_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jag_pad_pkg : Jaguar pad button bit map and input-filter state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package jag_pad_pkg;

  localparam int NUM_BUTTONS = 21;

  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_UP     = 3;
  localparam int BTN_A      = 4;
  localparam int BTN_B      = 5;
  localparam int BTN_C      = 6;
  localparam int BTN_OPTION = 7;
  localparam int BTN_PAUSE  = 8;
  localparam int BTN_0      = 9;
  localparam int BTN_1      = 10;
  localparam int BTN_2      = 11;
  localparam int BTN_3      = 12;
  localparam int BTN_4      = 13;
  localparam int BTN_5      = 14;
  localparam int BTN_6      = 15;
  localparam int BTN_7      = 16;
  localparam int BTN_8      = 17;
  localparam int BTN_9      = 18;
  localparam int BTN_STAR   = 19;
  localparam int BTN_HASH   = 20;

  // ST_COMMIT is the one-cycle hop used when committing without waiting for idle
  typedef enum logic [1:0] {
    ST_FILTER = 2'd0,
    ST_WAIT   = 2'd1,
    ST_COMMIT = 2'd2
  } pad_state_e;

endpackage
`default_nettype wire

// File: rtl/jag_sync2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jag_sync2 : generic-width two-flop synchroniser, async active-high reset
// Rev 1.0
// ---------------------------------------------------------------------------
module jag_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule
`default_nettype wire

// File: rtl/jag_pad_input_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jag_pad_input_sync : sync + debounce host buttons, optional scan-coherent commit
// Rev 1.0
// ---------------------------------------------------------------------------
module jag_pad_input_sync
  import jag_pad_pkg::*;
#(
  parameter int NUM_BUTTONS   = jag_pad_pkg::NUM_BUTTONS,
  parameter int STABLE_CYCLES = 16,
  parameter int MAX_WAIT      = 4096
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] joy_in,
  input  logic [3:0]             col_n,
  input  logic                   coherent_en,
  output logic [NUM_BUTTONS-1:0] buttons,
  output logic                   update_pulse,
  output logic                   pending
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int WW = $clog2(MAX_WAIT);
  localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  logic [NUM_BUTTONS-1:0] joy_s;
  logic [NUM_BUTTONS-1:0] cand_q;
  logic [NUM_BUTTONS-1:0] buttons_q;
  logic [SW-1:0]          stab_q;
  logic [SW-1:0]          stab_d;
  logic [WW-1:0]          wait_q;
  logic [3:0]             col_q;
  logic                   pulse_q;
  logic                   pending_q;
  pad_state_e             state_q;

  logic restart;
  logic stable;
  logic idle;

  jag_sync2 #(
    .WIDTH (NUM_BUTTONS)
  ) u_sync (
    .clk_i (sys_clk),
    .rst_i (reset),
    .d_i   (joy_in),
    .q_o   (joy_s)
  );

  assign restart = (joy_s != cand_q);
  // A restart on this edge voids stability even if the count is saturated
  assign stable  = (stab_q == STAB_MAX) && !restart;
  assign idle    = (col_q == 4'b1111);

  always_comb begin
    stab_d = stab_q;
    if (restart) begin
      stab_d = '0;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      cand_q <= '0;
      stab_q <= '0;
      col_q  <= 4'b1111;
    end else begin
      cand_q <= joy_s;
      stab_q <= stab_d;
      col_q  <= col_n;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FILTER;
      buttons_q <= '0;
      pulse_q   <= 1'b0;
      pending_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        ST_FILTER: begin
          if (stable && (cand_q != buttons_q)) begin
            if (coherent_en) begin
              state_q   <= ST_WAIT;
              pending_q <= 1'b1;
              wait_q    <= '0;
            end else begin
              state_q <= ST_COMMIT;
            end
          end
        end
        ST_COMMIT: begin
          buttons_q <= cand_q;
          pulse_q   <= 1'b1;
          state_q   <= ST_FILTER;
        end
        ST_WAIT: begin
          if (restart) begin
            state_q   <= ST_FILTER;
            pending_q <= 1'b0;
          end else if (!coherent_en || idle || (wait_q == WAIT_LAST)) begin
            buttons_q <= cand_q;
            pulse_q   <= 1'b1;
            pending_q <= 1'b0;
            state_q   <= ST_FILTER;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: begin
          state_q   <= ST_FILTER;
          pending_q <= 1'b0;
        end
      endcase
    end
  end

  // Fan out to the mux groups: d-pad, fire/option/pause, keypad
  always_comb begin
    buttons                       = '0;
    buttons[BTN_UP:BTN_RIGHT]     = buttons_q[BTN_UP:BTN_RIGHT];
    buttons[BTN_PAUSE:BTN_A]      = buttons_q[BTN_PAUSE:BTN_A];
    buttons[BTN_HASH:BTN_0]       = buttons_q[BTN_HASH:BTN_0];
  end

  assign update_pulse = pulse_q;
  assign pending      = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_jag_pad_input_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_jag_pad_input_sync : directed + randomized bench with a windowed reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_jag_pad_input_sync;
  import jag_pad_pkg::*;

  localparam int SC = 4;
  localparam int MW = 16;
  localparam int NB = NUM_BUTTONS;
  localparam int HD = SC + 4;

  logic          sys_clk = 1'b0;
  logic          reset;
  logic [NB-1:0] joy_in;
  logic [3:0]    col_n;
  logic          coherent_en;
  logic [NB-1:0] buttons;
  logic          update_pulse;
  logic          pending;

  jag_pad_input_sync #(
    .NUM_BUTTONS   (NB),
    .STABLE_CYCLES (SC),
    .MAX_WAIT      (MW)
  ) dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .joy_in       (joy_in),
    .col_n        (col_n),
    .coherent_en  (coherent_en),
    .buttons      (buttons),
    .update_pulse (update_pulse),
    .pending      (pending)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  // Model: history of sampled words; a value is accepted once the last SC+2
  // samples seen through the two-flop delay all agree.
  logic [NB-1:0] h [HD];
  logic [3:0]    ch [2];
  logic [NB-1:0] m_btn, m_val;
  logic          m_pulse, m_pend, m_next;
  int            m_wait;

  function automatic logic [NB-1:0] bm(input int idx);
    logic [NB-1:0] one;
    one = 1;
    return one << idx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < HD; k++) h[k] = '0;
    ch[0] = 4'hF; ch[1] = 4'hF;
    m_btn = '0; m_val = '0; m_pulse = 0; m_pend = 0; m_next = 0; m_wait = 0;
  endtask

  task automatic model_edge();
    logic stable;
    for (int k = HD - 1; k > 0; k--) h[k] = h[k-1];
    h[0] = joy_in;
    ch[1] = ch[0];
    ch[0] = col_n;
    stable = 1'b1;
    for (int k = 3; k < HD; k++) if (h[k] != h[2]) stable = 1'b0;
    m_pulse = 0;
    if (m_next) begin
      m_btn = m_val; m_pulse = 1; m_next = 0;
    end else if (m_pend) begin
      if (h[2] != h[3]) m_pend = 0;
      else if (!coherent_en || ch[1] == 4'hF || m_wait == MW - 1) begin
        m_btn = h[2]; m_pulse = 1; m_pend = 0;
      end else m_wait++;
    end else if (stable && h[2] != m_btn) begin
      if (!coherent_en) begin m_next = 1; m_val = h[2]; end
      else begin m_pend = 1; m_wait = 0; end
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_edge();
    #1;
    chk("buttons", 32'(buttons), 32'(m_btn));
    chk("update_pulse", 32'(update_pulse), 32'(m_pulse));
    chk("pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    reset = 1'b1;
    #1;
    chk("rst_buttons", 32'(buttons), 32'd0);
    chk("rst_pulse", 32'(update_pulse), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    model_reset();
    #2 reset = 1'b0;
  endtask

  logic [NB-1:0] pool [4];
  int pulses, rise, n, hold;

  initial begin
    reset = 1'b1; joy_in = '0; col_n = 4'hF; coherent_en = 1'b0;
    model_reset();
    #12 reset = 1'b0;

    // 1: async reset from an all-pressed state
    joy_in = {NB{1'b1}};
    repeat (10) step();
    chk("t1_full", 32'(buttons), 32'h1FFFFF);
    do_reset();
    step();
    chk("t1_after_release", 32'(buttons), 32'd0);

    // 2: non-coherent latency
    joy_in = '0; do_reset(); repeat (2) step();
    joy_in = bm(BTN_A);
    repeat (8) step();
    chk("t2_early", 32'(buttons), 32'd0);
    step();
    chk("t2_commit", 32'(buttons), 32'(bm(BTN_A)));
    chk("t2_pulse", 32'(update_pulse), 32'd1);
    step();
    chk("t2_pulse_off", 32'(update_pulse), 32'd0);

    // 3: glitch rejection, then a long pulse commits and releases
    joy_in = '0; do_reset(); repeat (2) step();
    joy_in = bm(BTN_UP); repeat (3) step();
    joy_in = '0; pulses = 0;
    repeat (15) begin step(); pulses += int'(update_pulse); end
    chk("t3_short_btn", 32'(buttons), 32'd0);
    chk("t3_short_pulses", 32'(pulses), 32'd0);
    joy_in = bm(BTN_UP); repeat (8) step();
    joy_in = '0; pulses = 0;
    repeat (15) begin step(); pulses += int'(update_pulse); end
    chk("t3_long_btn", 32'(buttons), 32'd0);
    chk("t3_long_pulses", 32'(pulses), 32'd2);

    // 4a: coherent, commit after column idle
    joy_in = '0; coherent_en = 1'b1; col_n = 4'b1110; do_reset(); repeat (2) step();
    joy_in = bm(BTN_PAUSE);
    repeat (9) step();
    chk("t4_pending", 32'(pending), 32'd1);
    chk("t4_held", 32'(buttons), 32'd0);
    col_n = 4'b1111; step();
    chk("t4_not_yet", 32'(buttons), 32'd0);
    step();
    chk("t4_commit", 32'(buttons), 32'(bm(BTN_PAUSE)));
    chk("t4_pulse", 32'(update_pulse), 32'd1);
    chk("t4_pending_off", 32'(pending), 32'd0);

    // 4b: forced commit when the column never idles
    joy_in = '0; col_n = 4'b1110; do_reset(); repeat (2) step();
    joy_in = bm(BTN_PAUSE); rise = -1;
    for (int i = 0; i < 40 && rise < 0; i++) begin step(); if (pending) rise = i; end
    chk("t4_rise_edge", 32'(rise), 32'd7);
    n = 0;
    while (buttons == '0 && n < 40) begin step(); n++; end
    chk("t4_forced_latency", 32'(n), 32'd16);

    // 5: new value while pending drops the old one
    joy_in = '0; col_n = 4'b1110; do_reset(); repeat (2) step();
    joy_in = bm(BTN_PAUSE); repeat (9) step();
    chk("t5_pending", 32'(pending), 32'd1);
    joy_in = bm(BTN_B); repeat (3) step();
    chk("t5_dropped", 32'(pending), 32'd0);
    chk("t5_no_commit", 32'(buttons), 32'd0);
    col_n = 4'b1111; repeat (12) step();
    chk("t5_b_alone", 32'(buttons), 32'(bm(BTN_B)));

    // 6: dropping coherent_en while pending commits next edge
    joy_in = '0; col_n = 4'b1110; do_reset(); repeat (2) step();
    joy_in = bm(BTN_PAUSE); repeat (9) step();
    chk("t6_pending", 32'(pending), 32'd1);
    coherent_en = 1'b0; step();
    chk("t6_commit", 32'(buttons), 32'(bm(BTN_PAUSE)));
    chk("t6_pulse", 32'(update_pulse), 32'd1);
    step();
    chk("t6_pulse_off", 32'(update_pulse), 32'd0);

    // 7: randomized words, strobes and mode against the model
    pool[0] = '0;
    for (int k = 1; k < 4; k++) pool[k] = NB'($urandom);
    joy_in = '0; do_reset();
    for (int seg = 0; seg < 120; seg++) begin
      if (seg == 60) do_reset();
      joy_in = pool[$urandom_range(0, 3)];
      coherent_en = ($urandom_range(0, 3) != 0);
      hold = $urandom_range(1, 14);
      repeat (hold) begin
        col_n = ($urandom_range(0, 5) == 0) ? 4'hF : 4'(~(1 << $urandom_range(0, 3)));
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
